// File: rtl/mac_pe.sv
// Weight-stationary multiply-accumulate processing element for the systolic array.
// Double-buffered weight; activations pass east and partial sums pass south through one register stage.
module mac_pe #(
    parameter int unsigned DATA_SIZE = 8,
    parameter int unsigned ACC_SIZE  = 32,
    parameter int unsigned SIGNED    = 1,
    parameter int unsigned SATURATE  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] w_in,
    input  logic                 w_valid,
    output logic                 w_ready,
    input  logic                 w_swap,
    output logic                 w_active_valid,
    input  logic [DATA_SIZE-1:0] act_in,
    input  logic                 act_valid_in,
    output logic [DATA_SIZE-1:0] act_out,
    output logic                 act_valid_out,
    input  logic [ACC_SIZE-1:0]  psum_in,
    output logic [ACC_SIZE-1:0]  psum_out,
    output logic                 psum_valid_out,
    output logic                 ovf
);

    localparam int unsigned PROD_SIZE = 2 * DATA_SIZE;

    localparam logic [ACC_SIZE-1:0] S_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic [ACC_SIZE-1:0] S_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};
    localparam logic [ACC_SIZE-1:0] U_MAX = {ACC_SIZE{1'b1}};

    // Bit 1 = active weight valid, bit 0 = shadow register full.
    typedef enum logic [1:0] {
        W_EMPTY = 2'b00,
        W_PEND0 = 2'b01,
        W_READY = 2'b10,
        W_PEND1 = 2'b11
    } wstate_e;

    wstate_e                state_q, state_d;
    logic [DATA_SIZE-1:0]   shadow_q, shadow_d;
    logic [DATA_SIZE-1:0]   active_q, active_d;
    logic                   ovf_q, ovf_d;
    logic [DATA_SIZE-1:0]   act_q;
    logic                   act_valid_q;
    logic [ACC_SIZE-1:0]    psum_q, psum_d;
    logic                   psum_valid_q;

    logic                   load_s;
    logic                   swap_s;
    logic [PROD_SIZE-1:0]   act_x_s;
    logic [PROD_SIZE-1:0]   w_x_s;
    logic [PROD_SIZE-1:0]   prod_s;
    logic [ACC_SIZE-1:0]    prod_ext_s;
    logic [ACC_SIZE:0]      sum_s;
    logic                   mac_ovf_s;
    logic [ACC_SIZE-1:0]    mac_res_s;

    assign load_s = w_valid & ~state_q[0];
    assign swap_s = w_swap & state_q[0];

    // Weight buffer state machine: next state and shadow/active register updates.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        case (state_q)
            W_EMPTY: begin
                if (load_s) state_d = W_PEND0;
                else        state_d = W_EMPTY;
            end
            W_PEND0: begin
                if (swap_s) state_d = W_READY;
                else        state_d = W_PEND0;
            end
            W_READY: begin
                if (load_s) state_d = W_PEND1;
                else        state_d = W_READY;
            end
            W_PEND1: begin
                if (swap_s) state_d = W_READY;
                else        state_d = W_PEND1;
            end
            default: state_d = W_EMPTY;
        endcase
        if (load_s) begin
            shadow_d = w_in;
        end else begin
            shadow_d = shadow_q;
        end
        if (swap_s) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
    end

    // Multiply-accumulate datapath with overflow detection and optional clamping.
    always_comb begin
        act_x_s    = {PROD_SIZE{1'b0}};
        w_x_s      = {PROD_SIZE{1'b0}};
        prod_ext_s = {ACC_SIZE{1'b0}};
        mac_ovf_s  = 1'b0;
        mac_res_s  = {ACC_SIZE{1'b0}};
        if (SIGNED != 0) begin
            act_x_s = {{DATA_SIZE{act_in[DATA_SIZE-1]}}, act_in};
            w_x_s   = {{DATA_SIZE{active_q[DATA_SIZE-1]}}, active_q};
        end else begin
            act_x_s = {{DATA_SIZE{1'b0}}, act_in};
            w_x_s   = {{DATA_SIZE{1'b0}}, active_q};
        end
        // The low PROD_SIZE bits of the widened product are exact for both signednesses.
        prod_s = act_x_s * w_x_s;
        if (SIGNED != 0) begin
            prod_ext_s = {ACC_SIZE{prod_s[PROD_SIZE-1]}};
        end else begin
            prod_ext_s = {ACC_SIZE{1'b0}};
        end
        prod_ext_s[PROD_SIZE-1:0] = prod_s;
        sum_s = {1'b0, psum_in} + {1'b0, prod_ext_s};
        if (SIGNED != 0) begin
            mac_ovf_s = (psum_in[ACC_SIZE-1] == prod_ext_s[ACC_SIZE-1]) &&
                        (sum_s[ACC_SIZE-1] != psum_in[ACC_SIZE-1]);
        end else begin
            mac_ovf_s = sum_s[ACC_SIZE];
        end
        if (mac_ovf_s && (SATURATE != 0)) begin
            if (SIGNED != 0) begin
                mac_res_s = psum_in[ACC_SIZE-1] ? S_MIN : S_MAX;
            end else begin
                mac_res_s = U_MAX;
            end
        end else begin
            mac_res_s = sum_s[ACC_SIZE-1:0];
        end
    end

    // Next partial sum and sticky overflow; a committed swap starts a fresh tile.
    always_comb begin
        psum_d = psum_in;
        ovf_d  = ovf_q;
        if (act_valid_in) begin
            psum_d = mac_res_s;
        end else begin
            psum_d = psum_in;
        end
        if (swap_s) begin
            ovf_d = 1'b0;
        end else if (act_valid_in && mac_ovf_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= W_EMPTY;
            shadow_q     <= {DATA_SIZE{1'b0}};
            active_q     <= {DATA_SIZE{1'b0}};
            ovf_q        <= 1'b0;
            act_q        <= {DATA_SIZE{1'b0}};
            act_valid_q  <= 1'b0;
            psum_q       <= {ACC_SIZE{1'b0}};
            psum_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            ovf_q        <= ovf_d;
            act_q        <= act_in;
            act_valid_q  <= act_valid_in;
            psum_q       <= psum_d;
            psum_valid_q <= act_valid_in;
        end
    end

    assign w_ready        = ~state_q[0];
    assign w_active_valid = state_q[1];
    assign act_out        = act_q;
    assign act_valid_out  = act_valid_q;
    assign psum_out       = psum_q;
    assign psum_valid_out = psum_valid_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: four instances (signed/unsigned x wrap/saturate) share one stimulus.
module tb_mac_pe;

    logic        clock;
    logic        reset;
    logic [7:0]  w_in;
    logic        w_valid;
    logic        w_swap;
    logic [7:0]  act_in;
    logic        act_valid_in;
    logic [31:0] psum_in;

    logic        ready_o  [4];
    logic        av_o     [4];
    logic [7:0]  act_o    [4];
    logic        act_v_o  [4];
    logic [31:0] psum_o   [4];
    logic        psum_v_o [4];
    logic        ovf_o    [4];

    int vectors;
    int miscompares;

    // Index 0: signed wrap, 1: signed saturate, 2: unsigned wrap, 3: unsigned saturate.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        mac_pe #(
            .DATA_SIZE(8),
            .ACC_SIZE (32),
            .SIGNED   ((g < 2) ? 1 : 0),
            .SATURATE (g % 2)
        ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .w_in          (w_in),
            .w_valid       (w_valid),
            .w_ready       (ready_o[g]),
            .w_swap        (w_swap),
            .w_active_valid(av_o[g]),
            .act_in        (act_in),
            .act_valid_in  (act_valid_in),
            .act_out       (act_o[g]),
            .act_valid_out (act_v_o[g]),
            .psum_in       (psum_in),
            .psum_out      (psum_o[g]),
            .psum_valid_out(psum_v_o[g]),
            .ovf           (ovf_o[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b0;
        w_in         = 8'd0;
        w_valid      = 1'b0;
        w_swap       = 1'b0;
        act_in       = 8'd0;
        act_valid_in = 1'b0;
        psum_in      = 32'd0;

        #2;
        chk1("rst_ready", ready_o[0], 1'b1);
        chk1("rst_av", av_o[0], 1'b0);
        chk("rst_psum", psum_o[0], 32'd0);
        chk1("rst_psum_v", psum_v_o[0], 1'b0);
        chk1("rst_ovf", ovf_o[0], 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Basic signed MAC: 100 + 5 * (-3) = 85; unsigned view 100 + 5 * 253 = 1365.
        w_in = 8'hFD; w_valid = 1'b1; tick(); w_valid = 1'b0;
        chk1("load_ready", ready_o[0], 1'b0);
        chk1("load_av", av_o[0], 1'b0);
        w_swap = 1'b1; tick(); w_swap = 1'b0;
        chk1("swap_av", av_o[0], 1'b1);
        chk1("swap_ready", ready_o[0], 1'b1);
        act_in = 8'd5; act_valid_in = 1'b1; psum_in = 32'd100; tick();
        chk("mac_s", psum_o[0], 32'd85);
        chk1("mac_psum_v", psum_v_o[0], 1'b1);
        chk("mac_act", {24'd0, act_o[0]}, 32'd5);
        chk1("mac_act_v", act_v_o[0], 1'b1);
        chk("mac_u", psum_o[2], 32'd1365);
        act_valid_in = 1'b0; psum_in = 32'd0;

        // Double buffer: active 2, shadow 7, second load stalled, swap mid-stream.
        w_in = 8'd2; w_valid = 1'b1; tick();
        w_valid = 1'b0; w_swap = 1'b1; tick();
        w_swap = 1'b0; w_in = 8'd7; w_valid = 1'b1; tick();
        chk1("db_ready0", ready_o[0], 1'b0);
        w_in = 8'd9; act_in = 8'd1; act_valid_in = 1'b1; psum_in = 32'd0; tick();
        chk("db_mac1", psum_o[0], 32'd2);
        chk1("db_stall", ready_o[0], 1'b0);
        w_valid = 1'b0; w_swap = 1'b1; tick();
        chk("db_mac2", psum_o[0], 32'd2);
        chk1("db_ready1", ready_o[0], 1'b1);
        w_swap = 1'b0; tick();
        chk("db_mac3", psum_o[0], 32'd7);
        tick();
        chk("db_mac4", psum_o[0], 32'd7);

        // Bubble passes psum unchanged.
        act_valid_in = 1'b0; psum_in = 32'h0000_1234; tick();
        chk("bubble", psum_o[0], 32'h0000_1234);
        chk("bubble_sat", psum_o[1], 32'h0000_1234);
        chk1("bubble_v", psum_v_o[0], 1'b0);

        // Swap with shadow empty, alone and together with an accepted load.
        w_swap = 1'b1; act_valid_in = 1'b1; act_in = 8'd1; psum_in = 32'd0; tick();
        chk("noop_swap_a", psum_o[0], 32'd7);
        w_swap = 1'b0; tick();
        chk("noop_swap_b", psum_o[0], 32'd7);
        w_in = 8'd3; w_valid = 1'b1; w_swap = 1'b1; tick();
        chk1("ld_sw_ready", ready_o[0], 1'b0);
        w_valid = 1'b0; w_swap = 1'b0; tick();
        chk("ld_sw_keep", psum_o[0], 32'd7);
        w_swap = 1'b1; tick();
        chk("ld_sw_edge", psum_o[0], 32'd7);
        w_swap = 1'b0; tick();
        chk("ld_sw_new", psum_o[0], 32'd3);
        act_valid_in = 1'b0;

        // Positive overflow: 0x7FFFFFF0 + 127 * 127.
        w_in = 8'd127; w_valid = 1'b1; tick();
        w_valid = 1'b0; w_swap = 1'b1; tick(); w_swap = 1'b0;
        act_in = 8'd127; psum_in = 32'h7FFF_FFF0; act_valid_in = 1'b1; tick();
        chk("ovf_wrap", psum_o[0], 32'h8000_3EF1);
        chk1("ovf_wrap_f", ovf_o[0], 1'b1);
        chk("ovf_sat", psum_o[1], 32'h7FFF_FFFF);
        chk1("ovf_sat_f", ovf_o[1], 1'b1);
        chk("ovf_uns", psum_o[2], 32'h8000_3EF1);
        chk1("ovf_uns_f", ovf_o[2], 1'b0);
        act_valid_in = 1'b0; w_swap = 1'b1; tick(); w_swap = 1'b0;
        chk1("ovf_sticky", ovf_o[0], 1'b1);
        w_in = 8'hFF; w_valid = 1'b1; tick();
        chk1("ovf_hold_load", ovf_o[1], 1'b1);
        w_valid = 1'b0; w_swap = 1'b1; tick(); w_swap = 1'b0;
        chk1("ovf_clear", ovf_o[0], 1'b0);
        chk1("ovf_clear_s", ovf_o[1], 1'b0);

        // Weight 0xFF: unsigned 255 * 255 + 1, signed (-1) * (-1) + 1.
        act_in = 8'hFF; psum_in = 32'd1; act_valid_in = 1'b1; tick();
        chk("uns_ff", psum_o[2], 32'h0000_FE02);
        chk("uns_ff_sat", psum_o[3], 32'h0000_FE02);
        chk("sgn_ff", psum_o[0], 32'd2);
        chk1("uns_ff_ovf", ovf_o[2], 1'b0);

        // Negative overflow: min + (-1).
        act_in = 8'd1; psum_in = 32'h8000_0000; tick();
        chk("neg_wrap", psum_o[0], 32'h7FFF_FFFF);
        chk1("neg_wrap_f", ovf_o[0], 1'b1);
        chk("neg_sat", psum_o[1], 32'h8000_0000);
        chk("neg_uns", psum_o[2], 32'h8000_00FF);

        // Unsigned carry out: 0xFFFFFFFF + 255.
        psum_in = 32'hFFFF_FFFF; tick();
        chk("carry_wrap", psum_o[2], 32'h0000_00FE);
        chk1("carry_wrap_f", ovf_o[2], 1'b1);
        chk("carry_sat", psum_o[3], 32'hFFFF_FFFF);
        chk1("carry_sat_f", ovf_o[3], 1'b1);
        chk("carry_sgn", psum_o[0], 32'hFFFF_FFFE);

        // Asynchronous reset mid-stream, then weights must be gone.
        act_in = 8'd3; psum_in = 32'd5;
        #2 reset = 1'b0;
        #1;
        chk("arst_psum", psum_o[0], 32'd0);
        chk("arst_act", {24'd0, act_o[0]}, 32'd0);
        chk1("arst_act_v", act_v_o[0], 1'b0);
        chk1("arst_psum_v", psum_v_o[0], 1'b0);
        chk1("arst_ready", ready_o[0], 1'b1);
        chk1("arst_av", av_o[0], 1'b0);
        chk1("arst_ovf", ovf_o[2], 1'b0);
        @(negedge clock);
        reset = 1'b1;
        tick();
        chk("post_rst_mac", psum_o[0], 32'd5);
        chk("post_rst_mac_u", psum_o[2], 32'd5);
        chk1("post_rst_av", av_o[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
